// File: rtl/nes_poll_scheduler.sv
// Polls two NES pads in parallel over a shared latch/clock bus at a programmable frame rate.
// Presents the current button state and sticky newly-pressed flags under a valid/ack handshake.
module nes_poll_scheduler #(
  parameter int TICK_DIV    = 500,
  parameter int POLL_TICKS  = 1666,
  parameter int LATCH_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        poll_now,
  input  logic        data0,
  input  logic        data1,
  output logic        nes_latch,
  output logic        nes_clk,
  output logic [7:0]  pad0_buttons,
  output logic [7:0]  pad1_buttons,
  output logic [7:0]  pad0_pressed,
  output logic [7:0]  pad1_pressed,
  output logic        evt_valid,
  input  logic        evt_ack,
  output logic        busy,
  output logic [15:0] scan_count
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDLE_W = $clog2(POLL_TICKS + 1);
  localparam int LAT_W  = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LATCH    = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_SHIFT_LO = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [DIV_W-1:0]  div_r;
  logic              tick_s;
  logic [2:0]        state_r, state_s;
  logic [IDLE_W-1:0] idle_r, idle_s;
  logic [LAT_W-1:0]  lat_r, lat_s;
  logic [2:0]        idx_r, idx_s;
  logic [7:0]        shift0_r, shift0_s, shift1_r, shift1_s;
  logic              pend_r, pend_s;
  logic [7:0]        new0_s, new1_s, press0_s, press1_s;

  assign tick_s = (div_r == DIV_W'(TICK_DIV - 1));

  // Free-running tick divider
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Scan sequencer next-state; all bus timing advances on tick only
  always_comb begin
    state_s  = state_r;
    idle_s   = idle_r;
    lat_s    = lat_r;
    idx_s    = idx_r;
    shift0_s = shift0_r;
    shift1_s = shift1_r;
    pend_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (tick_s) begin
          if (pend_r || poll_now || (enable && (idle_r >= IDLE_W'(POLL_TICKS - 1)))) begin
            state_s  = S_LATCH;
            idle_s   = '0;
            lat_s    = '0;
            shift0_s = 8'h00;
            shift1_s = 8'h00;
          end else if (enable) begin
            idle_s = idle_r + IDLE_W'(1);
          end else begin
            idle_s = idle_r;
          end
        end else begin
          pend_s = pend_r | poll_now;
        end
      end
      S_LATCH: begin
        if (tick_s) begin
          if (lat_r == LAT_W'(LATCH_TICKS - 1)) begin
            shift0_s[0] = ~data0;
            shift1_s[0] = ~data1;
            idx_s       = 3'd1;
            state_s     = S_SHIFT_HI;
          end else begin
            lat_s = lat_r + LAT_W'(1);
          end
        end else begin
          lat_s = lat_r;
        end
      end
      S_SHIFT_HI: begin
        if (tick_s) begin
          state_s = S_SHIFT_LO;
        end else begin
          state_s = S_SHIFT_HI;
        end
      end
      S_SHIFT_LO: begin
        if (tick_s) begin
          shift0_s[idx_r] = ~data0;
          shift1_s[idx_r] = ~data1;
          if (idx_r == 3'd7) begin
            state_s = S_DONE;
          end else begin
            idx_s   = idx_r + 3'd1;
            state_s = S_SHIFT_HI;
          end
        end else begin
          state_s = S_SHIFT_LO;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Sticky event flags; an ack in the commit cycle keeps only the fresh presses
  always_comb begin
    new0_s = shift0_r & ~pad0_buttons;
    new1_s = shift1_r & ~pad1_buttons;
    if (state_r == S_DONE) begin
      press0_s = evt_ack ? new0_s : (pad0_pressed | new0_s);
      press1_s = evt_ack ? new1_s : (pad1_pressed | new1_s);
    end else if (evt_ack) begin
      press0_s = 8'h00;
      press1_s = 8'h00;
    end else begin
      press0_s = pad0_pressed;
      press1_s = pad1_pressed;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      idle_r       <= '0;
      lat_r        <= '0;
      idx_r        <= 3'd0;
      shift0_r     <= 8'h00;
      shift1_r     <= 8'h00;
      pend_r       <= 1'b0;
      nes_latch    <= 1'b0;
      nes_clk      <= 1'b0;
      busy         <= 1'b0;
      pad0_buttons <= 8'h00;
      pad1_buttons <= 8'h00;
      pad0_pressed <= 8'h00;
      pad1_pressed <= 8'h00;
      evt_valid    <= 1'b0;
      scan_count   <= 16'h0000;
    end else begin
      state_r      <= state_s;
      idle_r       <= idle_s;
      lat_r        <= lat_s;
      idx_r        <= idx_s;
      shift0_r     <= shift0_s;
      shift1_r     <= shift1_s;
      pend_r       <= pend_s;
      nes_latch    <= (state_s == S_LATCH);
      nes_clk      <= (state_s == S_SHIFT_HI);
      busy         <= (state_s != S_IDLE);
      pad0_pressed <= press0_s;
      pad1_pressed <= press1_s;
      evt_valid    <= |{press0_s, press1_s};
      if (state_r == S_DONE) begin
        pad0_buttons <= shift0_r;
        pad1_buttons <= shift1_r;
        scan_count   <= scan_count + 16'd1;
      end else begin
        pad0_buttons <= pad0_buttons;
        pad1_buttons <= pad1_buttons;
        scan_count   <= scan_count;
      end
    end
  end

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// Self-checking bench for nes_poll_scheduler: pad models, scan vector table,
// randomized scans against a frame-level reference model, and corner sequences.
module tb_nes_poll_scheduler;

  localparam int TD = 4;
  localparam int PT = 20;
  localparam int LT = 2;
  localparam int SCAN_CLKS = TD * (LT + 14);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        poll_now = 1'b0;
  logic        data0, data1;
  logic        nes_latch, nes_clk;
  logic [7:0]  pad0_buttons, pad1_buttons, pad0_pressed, pad1_pressed;
  logic        evt_valid;
  logic        evt_ack = 1'b0;
  logic        busy;
  logic [15:0] scan_count;

  nes_poll_scheduler #(.TICK_DIV(TD), .POLL_TICKS(PT), .LATCH_TICKS(LT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .poll_now(poll_now),
    .data0(data0), .data1(data1), .nes_latch(nes_latch), .nes_clk(nes_clk),
    .pad0_buttons(pad0_buttons), .pad1_buttons(pad1_buttons),
    .pad0_pressed(pad0_pressed), .pad1_pressed(pad1_pressed),
    .evt_valid(evt_valid), .evt_ack(evt_ack), .busy(busy), .scan_count(scan_count)
  );

  always #5 clk = ~clk;

  // Pad models: latch presents bit0, each rising shift clock presents the next bit
  logic [7:0] pad0 = 8'h00, pad1 = 8'h00;
  logic [3:0] kidx = 4'd8;
  logic       prev_nclk = 1'b0;
  always @(negedge clk) begin
    if (nes_latch) kidx <= 4'd0;
    else if (nes_clk && !prev_nclk && kidx != 4'd8) kidx <= kidx + 4'd1;
    prev_nclk <= nes_clk;
  end
  assign data0 = kidx[3] ? 1'b1 : ~pad0[kidx[2:0]];
  assign data1 = kidx[3] ? 1'b1 : ~pad1[kidx[2:0]];

  int n_chk = 0, n_pass = 0;
  logic [7:0]  m_b0 = 8'h00, m_b1 = 8'h00, m_p0 = 8'h00, m_p1 = 8'h00;
  logic [15:0] m_cnt = 16'h0000;

  typedef struct {
    logic [7:0] b0, b1;
    bit         ack;
    logic [7:0] e_b0, e_b1, e_p0, e_p1;
    logic       e_v;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_b0"}, {8'h00, pad0_buttons}, {8'h00, m_b0});
    chk({tag, "_b1"}, {8'h00, pad1_buttons}, {8'h00, m_b1});
    chk({tag, "_p0"}, {8'h00, pad0_pressed}, {8'h00, m_p0});
    chk({tag, "_p1"}, {8'h00, pad1_pressed}, {8'h00, m_p1});
    chk({tag, "_valid"}, {15'h0, evt_valid}, {15'h0, |{m_p0, m_p1}});
    chk({tag, "_count"}, scan_count, m_cnt);
  endtask

  // Frame-level rule: buttons follow the pads, presses are new highs vs last frame
  task automatic model_scan(input bit ack_same);
    logic [7:0] n0, n1;
    n0 = pad0 & ~m_b0;
    n1 = pad1 & ~m_b1;
    m_p0 = ack_same ? n0 : (m_p0 | n0);
    m_p1 = ack_same ? n1 : (m_p1 | n1);
    m_b0 = pad0;
    m_b1 = pad1;
    m_cnt = m_cnt + 16'd1;
  endtask

  task automatic do_ack();
    evt_ack = 1'b1; step(); evt_ack = 1'b0;
    m_p0 = 8'h00; m_p1 = 8'h00;
    chk("ack_clear", {7'h0, evt_valid, pad0_pressed}, 16'h0000);
    chk("ack_clear_p1", {8'h00, pad1_pressed}, 16'h0000);
  endtask

  // One poll_now scan; a second poll_now mid-scan must be ignored
  task automatic do_scan(input bit ack_in_done);
    int n;
    poll_now = 1'b1; step(); poll_now = 1'b0;
    n = 0;
    while (!busy && n < 20) begin step(); n++; end
    chk("scan_start", {15'h0, busy}, 16'h0001);
    chk("scan_latch", {15'h0, nes_latch}, 16'h0001);
    repeat (10) step();
    poll_now = 1'b1; step(); poll_now = 1'b0;
    if (ack_in_done) begin
      repeat (SCAN_CLKS - 11) step();
      chk("done_busy", {15'h0, busy}, 16'h0001);
      evt_ack = 1'b1; step(); evt_ack = 1'b0;
    end else begin
      n = 0;
      while (busy && n < 200) begin step(); n++; end
    end
    chk("scan_end", {15'h0, busy}, 16'h0000);
    model_scan(ack_in_done);
  endtask

  initial begin
    int n, lat_hi, clk_hi, clk_rise, busy_hi;
    logic pc;

    tbl[0] = '{8'h09, 8'h80, 1'b0, 8'h09, 8'h80, 8'h09, 8'h80, 1'b1};
    tbl[1] = '{8'h09, 8'h80, 1'b1, 8'h09, 8'h80, 8'h00, 8'h00, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{8'h09, 8'hC0, 1'b0, 8'h09, 8'hC0, 8'h09, 8'hC0, 1'b1};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 8'hF6, 8'h3F, 1'b1};
    tbl[5] = '{8'h09, 8'h80, 1'b0, 8'h09, 8'h80, 8'hF6, 8'h3F, 1'b1};

    // Reset and first periodic scan timing
    pad0 = 8'h09; pad1 = 8'h80;
    reset = 1'b0; enable = 1'b1;
    repeat (3) step();
    chk("rst_bus", {14'h0, nes_latch, nes_clk}, 16'h0000);
    chk("rst_busy_valid", {14'h0, busy, evt_valid}, 16'h0000);
    chk("rst_buttons", {pad0_buttons, pad1_buttons}, 16'h0000);
    chk("rst_pressed", {pad0_pressed, pad1_pressed}, 16'h0000);
    chk("rst_count", scan_count, 16'h0000);
    reset = 1'b1;
    n = 0;
    do begin step(); n++; end while (!nes_latch && n < 200);
    chk("first_latch_clks", n[15:0], 16'(PT * TD));
    lat_hi = 1; clk_hi = 0; clk_rise = 0; busy_hi = busy ? 1 : 0; pc = 1'b0; n = 0;
    while (busy && n < 200) begin
      step(); n++;
      if (busy) busy_hi++;
      if (nes_latch) lat_hi++;
      if (nes_clk) clk_hi++;
      if (nes_clk && !pc) clk_rise++;
      pc = nes_clk;
    end
    enable = 1'b0;
    chk("latch_high_clks", lat_hi[15:0], 16'(LT * TD));
    chk("nes_clk_pulses", clk_rise[15:0], 16'd7);
    chk("nes_clk_high_clks", clk_hi[15:0], 16'(7 * TD));
    // scan ticks plus the one-cycle commit state
    chk("busy_clks", busy_hi[15:0], 16'(SCAN_CLKS + 1));
    model_scan(1'b0);
    check_model("scan1");

    // Table-driven scans with enable low
    for (int i = 0; i < 6; i++) begin
      pad0 = tbl[i].b0; pad1 = tbl[i].b1;
      if (tbl[i].ack) do_ack();
      do_scan(1'b0);
      chk($sformatf("tbl%0d_buttons", i), {pad0_buttons, pad1_buttons}, {tbl[i].e_b0, tbl[i].e_b1});
      chk($sformatf("tbl%0d_pressed", i), {pad0_pressed, pad1_pressed}, {tbl[i].e_p0, tbl[i].e_p1});
      chk($sformatf("tbl%0d_valid", i), {15'h0, evt_valid}, {15'h0, tbl[i].e_v});
      chk($sformatf("tbl%0d_count", i), scan_count, 16'(i + 2));
    end

    // Ack in the exact commit cycle while a new button appears
    pad0 = 8'h0B; pad1 = 8'h80;
    do_scan(1'b1);
    chk("ack_done_p0", {8'h00, pad0_pressed}, 16'h0002);
    chk("ack_done_p1", {8'h00, pad1_pressed}, 16'h0000);
    chk("ack_done_valid", {15'h0, evt_valid}, 16'h0001);
    check_model("ack_done");

    // No further scans with enable low
    repeat (300) step();
    chk("idle_hold_count", scan_count, m_cnt);
    chk("idle_hold_busy", {15'h0, busy}, 16'h0000);

    // Randomized scans against the reference model
    for (int r = 0; r < 12; r++) begin
      pad0 = 8'($urandom); pad1 = (r % 4 == 3) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 2) == 0) do_ack();
      do_scan($urandom_range(0, 3) == 0);
      check_model($sformatf("rnd%0d", r));
    end

    // Reset in the middle of a scan at bit index 4
    pad0 = 8'h5A; pad1 = 8'hA5;
    poll_now = 1'b1; step(); poll_now = 1'b0;
    clk_rise = 0; pc = 1'b0; n = 0;
    while (clk_rise < 4 && n < 300) begin
      step(); n++;
      if (nes_clk && !pc) clk_rise++;
      pc = nes_clk;
    end
    chk("mid_reset_reach", clk_rise[15:0], 16'd4);
    reset = 1'b0; step();
    chk("mid_reset_bus", {14'h0, nes_latch, nes_clk}, 16'h0000);
    chk("mid_reset_busy", {14'h0, busy, evt_valid}, 16'h0000);
    chk("mid_reset_buttons", {pad0_buttons, pad1_buttons}, 16'h0000);
    chk("mid_reset_count", scan_count, 16'h0000);
    step();
    reset = 1'b1;
    m_b0 = 8'h00; m_b1 = 8'h00; m_p0 = 8'h00; m_p1 = 8'h00; m_cnt = 16'h0000;
    do_scan(1'b0);
    check_model("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
